// File: rtl/secded_decodificador_pkg.sv
// ============================================================================
// Module : secded_pkg
// Brief  : Shared types and layout helpers for the SECDED decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package secded_pkg;

  typedef enum logic [1:0] {
    SIN_ERROR    = 2'd0,
    ERROR_SIMPLE = 2'd1,
    ERROR_DOBLE  = 2'd2
  } clase_error_t;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_par_w(int data_w);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  // Codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic int pos_dato(int idx);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) res = p;
        n = n + 1;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/secded_decodificador_if.sv
// ============================================================================
// Module : secded_decodificador_if
// Brief  : Input/output handshake bundle of the SECDED decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface secded_decodificador_if
  import secded_pkg::*;
#(
  parameter int DATA_W = 4
);
  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] palabra_rx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dato_out;
  logic [PAR_W-1:0]  pos_error;
  logic              sin_error;
  logic              error_simple;
  logic              error_doble;

  modport master (
    output in_valid, palabra_rx, out_ready,
    input  in_ready, out_valid, dato_out, pos_error,
           sin_error, error_simple, error_doble
  );

  modport slave (
    input  in_valid, palabra_rx, out_ready,
    output in_ready, out_valid, dato_out, pos_error,
           sin_error, error_simple, error_doble
  );

endinterface

`default_nettype wire

// File: rtl/secded_decodificador_sindrome.sv
// ============================================================================
// Module : secded_sindrome
// Brief  : Combinational Hamming syndrome and overall parity of a codeword.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module secded_sindrome #(
  parameter int CODE_W = 8,
  parameter int PAR_W  = 3
) (
  input  logic [CODE_W-1:0] i_palabra,
  output logic [PAR_W-1:0]  o_sindrome,
  output logic              o_paridad
);

  logic [PAR_W-1:0] w_sind;

  always_comb begin
    w_sind = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (i_palabra[i]) w_sind = w_sind ^ PAR_W'(i);
    end
  end

  assign o_sindrome = w_sind;
  assign o_paridad  = ^i_palabra;

endmodule

`default_nettype wire

// File: rtl/secded_decodificador.sv
// ============================================================================
// Module : secded_decodificador
// Brief  : Two-stage pipelined SECDED decoder with valid/ready handshake.
//          Optional SECDED_CNT_EN adds saturating single/double error counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module secded_decodificador
  import secded_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  secded_decodificador_if.slave  bus
`ifdef SECDED_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       cnt_simple,
  output logic [CNT_W-1:0]       cnt_doble
`endif
);

  localparam int            PAR_W      = calc_par_w(DATA_W);
  localparam int            CODE_W     = DATA_W + PAR_W + 1;
  localparam logic [PAR_W:0] CODE_W_EXT = (PAR_W + 1)'(CODE_W);

  logic              r_v1;
  logic [PAR_W-1:0]  r_sind;
  logic              r_par;
  logic [CODE_W-1:0] r_cw;

  logic              r_v2;
  logic [DATA_W-1:0] r_dato;
  logic [PAR_W-1:0]  r_pos;
  logic              r_sin;
  logic              r_simple;
  logic              r_doble;

  logic [PAR_W-1:0]  w_sind;
  logic              w_par;
  logic              w_adv;
  logic              w_in_ready;
  clase_error_t      w_clase;
  logic [CODE_W-1:0] w_flip;
  logic [CODE_W-1:0] w_cw_corr;
  logic [DATA_W-1:0] w_dato;

  secded_sindrome #(
    .CODE_W (CODE_W),
    .PAR_W  (PAR_W)
  ) u_sindrome (
    .i_palabra  (bus.palabra_rx),
    .o_sindrome (w_sind),
    .o_paridad  (w_par)
  );

  assign w_adv        = !r_v2 || bus.out_ready;
  assign w_in_ready   = !r_v1 || w_adv;
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_sind <= '0;
      r_par  <= 1'b0;
      r_cw   <= '0;
    end else if (w_in_ready) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_sind <= w_sind;
        r_par  <= w_par;
        r_cw   <= bus.palabra_rx;
      end
    end
  end

  // Odd parity with an out-of-range syndrome cannot be a single flip.
  always_comb begin
    w_clase = SIN_ERROR;
    if (r_par) begin
      w_clase = ({1'b0, r_sind} < CODE_W_EXT) ? ERROR_SIMPLE : ERROR_DOBLE;
    end else if (r_sind != '0) begin
      w_clase = ERROR_DOBLE;
    end
  end

  // Flip mask is empty unless the error is single, so doubles pass raw data.
  for (genvar i = 0; i < CODE_W; i++) begin : g_flip
    assign w_flip[i] = (w_clase == ERROR_SIMPLE) && (r_sind == PAR_W'(i));
  end

  assign w_cw_corr = r_cw ^ w_flip;

  for (genvar k = 0; k < DATA_W; k++) begin : g_dato
    localparam int P = pos_dato(k);
    assign w_dato[k] = w_cw_corr[P];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_dato   <= '0;
      r_pos    <= '0;
      r_sin    <= 1'b0;
      r_simple <= 1'b0;
      r_doble  <= 1'b0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dato   <= w_dato;
        r_pos    <= r_sind;
        r_sin    <= (w_clase == SIN_ERROR);
        r_simple <= (w_clase == ERROR_SIMPLE);
        r_doble  <= (w_clase == ERROR_DOBLE);
      end
    end
  end

  assign bus.out_valid    = r_v2;
  assign bus.dato_out     = r_dato;
  assign bus.pos_error    = r_pos;
  assign bus.sin_error    = r_sin;
  assign bus.error_simple = r_simple;
  assign bus.error_doble  = r_doble;

`ifdef SECDED_CNT_EN
  logic             w_xfer;
  logic [CNT_W-1:0] r_cnt_simple;
  logic [CNT_W-1:0] r_cnt_doble;

  assign w_xfer = r_v2 && bus.out_ready;

  // Clear has priority over a coinciding increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_simple <= '0;
      r_cnt_doble  <= '0;
    end else if (cnt_clr) begin
      r_cnt_simple <= '0;
      r_cnt_doble  <= '0;
    end else begin
      if (w_xfer && r_simple && (r_cnt_simple != '1)) begin
        r_cnt_simple <= r_cnt_simple + CNT_W'(1);
      end
      if (w_xfer && r_doble && (r_cnt_doble != '1)) begin
        r_cnt_doble <= r_cnt_doble + CNT_W'(1);
      end
    end
  end

  assign cnt_simple = r_cnt_simple;
  assign cnt_doble  = r_cnt_doble;
`endif

endmodule

`default_nettype wire
